fp_mul: RTL and testbench
=========================

Name: fp_mul

Overview:
- Sequential IEEE-754 single-precision multiplier. No start/valid handshake.
- Continuously captures operands a_s/b_s and forms the 24x24 significand product with an iterative shift-add datapath.
- Registers a truncated, normalized result plus an overflow flag.
- Used as a compact, low-area FP multiply unit wherever an operand pair is held stable for tens of cycles.

Parameters:
- MAN_W, 23, stored fraction width. Fixed for binary32; do not change.
- EXP_W, 8, exponent width. Fixed.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a_s  input  32  operand A (binary32: sign, exp[30:23], frac[22:0])
- b_s  input  32  operand B (binary32)
- c_out  output  32  registered product (binary32)
- overflow  output  1  registered; 1 when the last completed product overflowed to infinity

Behaviour:
- Reset (rst=1 at a clk edge): c_out=0x00000000, overflow=0, FSM to LOAD, iteration counter=0, internal operand copies cleared.
- States: LOAD -> MUL -> NORM -> DONE -> LOAD. The FSM free-runs.
- LOAD (1 cycle):
  - Capture a_s/b_s into internal copies.
  - Unpack: sign, exponent, 24-bit significand with hidden 1.
  - Clear the 48-bit accumulator and set counter=0.
- MUL (24 cycles), per cycle:
  - If the multiplier LSB is 1, add the multiplicand into the accumulator.
  - Shift, counter++.
  - Leave MUL when counter=23 completes.
- NORM (1 cycle):
  - If product[47]=1: fraction = product[46:24], exponent += 1; else fraction = product[45:23].
  - Rounding is truncation (round toward zero); discarded bits are dropped.
- DONE (1 cycle): write c_out and overflow. Both hold until the next DONE.
- Operand-change restart: in any state other than LOAD, if a_s or b_s differs from the captured copy, go to LOAD on the next edge and abandon the in-flight product. Outputs keep their old values.
- Latency: c_out is correct ≤ 30 cycles after the last operand change. Steady operands recompute the same value every 27 cycles.
- Sign: a_sign XOR b_sign, for every result including zero and infinity.
- Exponent: E = ea + eb − 127 (+1 on normalize shift), computed in ≥10-bit signed arithmetic.
- Special cases are resolved at LOAD and override the datapath result at DONE. Listed in priority order:
  1. Either operand NaN, or Inf×0 -> c_out=0x7FC00000, overflow=0.
  2. Either operand Inf -> signed infinity, overflow=0.
  3. Either operand zero or denormal (exp=0; denormals are flushed) -> signed zero, overflow=0.
- Overflow: final E ≥ 255 -> c_out = {sign, 0xFF, 0}, overflow=1.
- Underflow: final E ≤ 0 -> c_out = {sign, 31'b0}, overflow=0. Flush to zero; no denormal outputs.
- Reset asserted mid-computation wins unconditionally and returns the block to the reset state.

Test Plan:
- 0x40000000 (2.0) × 0xBF000000 (−0.5), wait 50 cycles -> c_out=0xBF800000, overflow=0. Also 2.0×0.5 -> 0x3F800000.
- Sign combinations:
  - 0xBE800000 (−0.25) × 0xBE000000 (−0.125) -> 0x3D000000.
  - −0.25 × 0x3E000000 (+0.125) -> 0xBD000000.
  - 0x3F800000 × 0x3F000000 -> 0x3F000000.
- Zero and special operands:
  - 0x00000000 × 0x40A00000 -> 0x00000000.
  - 0x7F800000 × 0 -> 0x7FC00000.
- Overflow: 0x7F5FFFFE × 0x7F5FFFFF -> c_out=0x7F800000, overflow=1. A following in-range pair returns overflow to 0.
- Underflow: 0x80800000 × 0x01400001 -> 0x80000000, overflow=0.
- Truncation and restart:
  - 0xC1900000 × 0x41180000 -> 0xC32B0000.
  - 0xC0933333 × 0x40933333 -> 0xC1A947AD (truncated, not rounded).
  - Change operands mid-MUL -> new result within 30 cycles of the change.
  - Assert rst mid-MUL -> c_out=0, overflow=0.

Source files
------------

// File: rtl/fp_mul.sv
// fp_mul: iterative shift-add IEEE-754 binary32 multiplier with truncation and overflow flag
module fp_mul #(
  parameter int MAN_W = 23,
  parameter int EXP_W = 8,
  parameter int BIAS  = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_s,
  input  logic [31:0] b_s,
  output logic [31:0] c_out,
  output logic        overflow
);
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EZERO = '0;
  localparam logic signed [XW-1:0] EONE = XW'(1);
  typedef enum logic [1:0] {LOAD, MUL, NORM, DONE} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_ZERO, SP_INF, SP_NAN} spec_t;
  state_t state, state_n;
  spec_t spec, spec_n;
  logic [31:0] a_r, b_r;
  logic sign;
  logic signed [XW-1:0] exp_r, exp_n;
  logic [PW-1:0] mcand, acc;
  logic [SW-1:0] mplier;
  logic [4:0] cnt;
  logic [MAN_W-1:0] frac, fa, fb;
  logic [EXP_W-1:0] ea, eb;
  logic a_z, b_z, a_inf, b_inf, a_nan, b_nan, changed, ov_n;
  logic [31:0] inf_v, res_n;
  assign ea = a_s[MAN_W +: EXP_W];
  assign eb = b_s[MAN_W +: EXP_W];
  assign fa = a_s[MAN_W-1:0];
  assign fb = b_s[MAN_W-1:0];
  assign a_z = ~|ea;
  assign b_z = ~|eb;
  assign a_inf = &ea & ~|fa;
  assign b_inf = &eb & ~|fb;
  assign a_nan = &ea & |fa;
  assign b_nan = &eb & |fb;
  assign changed = (a_s != a_r) || (b_s != b_r);
  assign exp_n = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;
  assign inf_v = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  always_comb begin
    state_n = (state != LOAD && changed) ? LOAD :
              state == LOAD ? MUL :
              state == MUL  ? (cnt == 5'(MAN_W) ? NORM : MUL) :
              state == NORM ? DONE : LOAD;
    spec_n = (a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z)) ? SP_NAN :
             (a_inf || b_inf) ? SP_INF :
             (a_z || b_z) ? SP_ZERO : SP_NONE;
    ov_n = spec == SP_NONE && exp_r >= EMAX;
    res_n = spec == SP_NAN  ? 32'h7FC0_0000 :
            spec == SP_INF  ? inf_v :
            spec == SP_ZERO ? {sign, 31'b0} :
            exp_r >= EMAX   ? inf_v :
            exp_r <= EZERO  ? {sign, 31'b0} :
            {sign, exp_r[EXP_W-1:0], frac};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      spec <= SP_NONE;
      a_r <= '0;
      b_r <= '0;
      sign <= 1'b0;
      exp_r <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      frac <= '0;
      c_out <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        LOAD: begin
          a_r <= a_s;
          b_r <= b_s;
          sign <= a_s[31] ^ b_s[31];
          exp_r <= exp_n;
          spec <= spec_n;
          mcand <= PW'({1'b1, fa});
          mplier <= {1'b1, fb};
          acc <= '0;
          cnt <= '0;
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
          cnt <= cnt + 5'd1;
        end
        NORM: begin
          if (acc[PW-1]) begin
            frac <= acc[PW-2 -: MAN_W];
            exp_r <= exp_r + EONE;
          end else begin
            frac <= acc[PW-3 -: MAN_W];
          end
        end
        DONE: begin
          // an operand change abandons this product, so the old result stays visible
          if (!changed) begin
            c_out <= res_n;
            overflow <= ov_n;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mul.sv
// tb_fp_mul: randomized and directed checks of fp_mul against a plain-arithmetic reference
module tb_fp_mul;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] a_s = '0, b_s = '0;
  logic [31:0] c_out;
  logic overflow;
  int compared = 0, mismatched = 0;
  int age = 0;
  logic [31:0] pa = '0, pb = '0;

  fp_mul dut (.clk(clk), .rst(rst), .a_s(a_s), .b_s(b_s), .c_out(c_out), .overflow(overflow));

  always #5 clk = ~clk;

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e;
    logic [47:0] p;
    logic [22:0] f;
    logic an, bn, ai, bi, az, bz;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = ea == 255 && a[22:0] != 0;
    bn = eb == 255 && b[22:0] != 0;
    ai = ea == 255 && a[22:0] == 0;
    bi = eb == 255 && b[22:0] == 0;
    az = ea == 0;
    bz = eb == 0;
    if (an || bn || (ai && bz) || (bi && az)) return {1'b0, 32'h7FC0_0000};
    if (ai || bi) return {1'b0, s, 8'hFF, 23'h0};
    if (az || bz) return {1'b0, s, 31'h0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p[47]) begin
      f = p[46:24];
      e++;
    end else begin
      f = p[45:23];
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
    if (e <= 0) return {1'b0, s, 31'h0};
    return {1'b0, s, e[7:0], f};
  endfunction

  // once operands have been stable for 30 edges the outputs must match the model every cycle
  always @(negedge clk) begin
    logic [32:0] m;
    if (rst || a_s != pa || b_s != pb) age = 0;
    else if (age < 1000) age++;
    pa = a_s;
    pb = b_s;
    if (age >= 30) begin
      m = model(a_s, b_s);
      compared++;
      if ({overflow, c_out} !== m) begin
        mismatched++;
        $display("FAIL steady a=%h b=%h got c=%h ov=%b want c=%h ov=%b", a_s, b_s, c_out, overflow, m[31:0], m[32]);
      end
    end
  end

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input int n);
    @(posedge clk);
    #2;
    a_s = a;
    b_s = b;
    repeat (n) @(posedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] c, input logic ov);
    @(negedge clk);
    compared++;
    if (c_out !== c || overflow !== ov) begin
      mismatched++;
      $display("FAIL %s got c=%h ov=%b want c=%h ov=%b", name, c_out, overflow, c, ov);
    end
  endtask

  typedef struct {
    logic [31:0] a, b, c;
    logic ov;
  } vec_t;
  vec_t vt[15] = '{
    '{32'h40000000, 32'hBF000000, 32'hBF800000, 1'b0},
    '{32'h40000000, 32'h3F000000, 32'h3F800000, 1'b0},
    '{32'hBE800000, 32'hBE000000, 32'h3D000000, 1'b0},
    '{32'hBE800000, 32'h3E000000, 32'hBD000000, 1'b0},
    '{32'h3F800000, 32'h3F000000, 32'h3F000000, 1'b0},
    '{32'h00000000, 32'h40A00000, 32'h00000000, 1'b0},
    '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0},
    '{32'h7F5FFFFE, 32'h7F5FFFFF, 32'h7F800000, 1'b1},
    '{32'h40000000, 32'h3F000000, 32'h3F800000, 1'b0},
    '{32'h80800000, 32'h01400001, 32'h80000000, 1'b0},
    '{32'hC1900000, 32'h41180000, 32'hC32B0000, 1'b0},
    '{32'hC0933333, 32'h40933333, 32'hC1A947AD, 1'b0},
    '{32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0},
    '{32'h00000001, 32'h40000000, 32'h00000000, 1'b0},
    '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0}
  };

  function automatic logic [31:0] rnd_op();
    logic [7:0] e;
    int k;
    k = int'($urandom_range(0, 9));
    e = k == 0 ? 8'h00 : k == 1 ? 8'hFF : k == 2 ? 8'(254 - $urandom_range(0, 3)) :
        k == 3 ? 8'($urandom_range(1, 4)) : 8'($urandom_range(90, 165));
    return {1'($urandom_range(0, 1)), e, (k == 1 && $urandom_range(0, 1) == 1) ? 23'h0 : 23'($urandom)};
  endfunction

  initial begin
    logic [32:0] m;
    repeat (2) @(posedge clk);
    check("reset", 32'h0, 1'b0);
    #2;
    rst = 1'b0;
    foreach (vt[i]) begin
      m = model(vt[i].a, vt[i].b);
      compared++;
      if (m !== {vt[i].ov, vt[i].c}) begin
        mismatched++;
        $display("FAIL model_vec%0d got c=%h ov=%b want c=%h ov=%b", i, m[31:0], m[32], vt[i].c, vt[i].ov);
      end
      apply(vt[i].a, vt[i].b, 30 + int'($urandom_range(0, 5)));
      check($sformatf("vec%0d", i), vt[i].c, vt[i].ov);
    end
    apply(32'h40000000, 32'hBF000000, 10);
    apply(32'hC1900000, 32'h41180000, 30);
    check("restart_mid_mul", 32'hC32B0000, 1'b0);
    apply(32'h40000000, 32'h3F000000, 10);
    #2;
    rst = 1'b1;
    @(posedge clk);
    check("rst_mid_mul", 32'h0, 1'b0);
    #2;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    check("after_rst", 32'h3F800000, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) apply(rnd_op(), rnd_op(), int'($urandom_range(1, 20)));
      apply(rnd_op(), rnd_op(), 31 + int'($urandom_range(0, 10)));
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
